fetch_prefetch_stage: RTL and testbench
=======================================

// Module: fetch_prefetch_stage
// PURPOSE
//  IF stage with a DEPTH-entry instruction prefetch queue, replacing the bare PC/imem fetch.
//  Decouples a valid/ready instruction memory from the IF/ID pipeline register.
//  Supports decode stall and redirect/flush, so the hazard-controlled pipeline can use it.
//  Drives InstrD/PCD/PCPlus4D into decode, and takes PCSrcE/PCTargetE back from execute.
// PARAMETERS
//  DEPTH    4             prefetch queue entries and max in-flight requests (power of 2, >=2)
//  RESET_PC 32'h00000000  first fetch address after reset
//  NOP      32'h00000013  bubble instruction (addi x0,x0,0)
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous reset, active-high
//  StallD         in   1   hold the IF/ID register; queue still fills
//  FlushD         in   1   load a bubble into IF/ID this cycle
//  PCSrcE         in   1   redirect request from execute (taken branch/jump)
//  PCTargetE      in   32  redirect target, word aligned
//  imem_req_valid out  1   fetch request valid
//  imem_req_addr  out  32  fetch address (= PCF)
//  imem_req_ready in   1   imem accepts the request
//  imem_rsp_valid in   1   instruction return, in request order, always accepted
//  imem_rsp_data  in   32  returned instruction
//  InstrD         out  32  IF/ID instruction
//  PCD            out  32  IF/ID PC
//  PCPlus4D       out  32  IF/ID PC+4
//  ValidD         out  1   IF/ID holds a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset (async): PCF=RESET_PC, rsp_pc=RESET_PC, queue empty, outstanding=0, discard=0,
//   InstrD=NOP, PCD=0, PCPlus4D=4, ValidD=0; imem_req_valid=0 while rst is high.
//  Credit: imem_req_valid = !rst && !PCSrcE && (outstanding + count < DEPTH).
//   The queue can never overflow, so no rsp_ready exists.
//  Request handshake (valid && ready): PCF += 4, outstanding += 1. Address is held stable while
//   valid && !ready. Addition wraps mod 2^32.
//  Response: outstanding -= 1. If discard>0, the instruction is dropped and discard -= 1.
//   Otherwise {rsp_pc, data} is pushed and rsp_pc += 4.
//  IF/ID update, in priority order:
//   1) PCSrcE | FlushD: bubble (InstrD=NOP, ValidD=0, PCD/PCPlus4D hold).
//   2) StallD: hold all IF/ID outputs.
//   3) queue non-empty: pop head; InstrD/PCD load from the entry, PCPlus4D=PC+4, ValidD=1.
//   4) queue empty: bubble.
//  Bypass: a response arriving while the queue is empty and discard=0 is pushed; it is popped
//   the next cycle. Response-to-ValidD latency is therefore 2 cycles (no combinational path).
//  Redirect (PCSrcE=1):
//   - PCF <= PCTargetE, rsp_pc <= PCTargetE, queue cleared.
//   - discard <= discard + outstanding - rsp_fire, i.e. every request still in flight after
//     this cycle is squashed. A response arriving in the redirect cycle is itself dropped.
//   - No request issues in the redirect cycle.
//   - Redirect beats StallD and simultaneous push/pop.
//  Simultaneous push and pop on a full queue is legal; count is unchanged.
//  FlushD without PCSrcE only bubbles IF/ID; queue and PC are unaffected.
//  Back-to-back redirects: each redirect recomputes discard; only the last target is fetched.
//  Reset mid-operation: all state clears immediately. The bench must not return responses
//   for pre-reset requests.
// TESTING
//  T1 reset then imem ready=1, 1-cycle latency, words W0..W7 -> PCD 0,4,8.. with
//   InstrD=W0,W1..; ValidD rises 3 cycles after rst falls; one instruction per cycle.
//  T2 StallD=1 for 6 cycles while streaming -> IF/ID held; exactly DEPTH(4) requests issue,
//   then req_valid=0; on release, no instruction is lost or duplicated.
//  T3 3 requests in flight, PCSrcE=1, PCTargetE=0x100 -> req_valid=0 that cycle; 3 stale
//   responses dropped; next ValidD shows PCD=0x100, PCPlus4D=0x104.
//  T4 PCSrcE coincident with a response and with StallD=1 -> response dropped, IF/ID bubble,
//   discard = outstanding-1.
//  T5 imem_req_ready toggling randomly and latency 1..3 -> PC sequence is strictly +4, no
//   overflow; FlushD pulse inserts exactly one NOP with ValidD=0.
//  T6 assert rst mid-stream -> all outputs return to reset values the same cycle; fetch
//   restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch_stage
// Purpose  : IF stage with a DEPTH-entry prefetch queue between a valid/ready
//            instruction memory and the IF/ID pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_prefetch_stage #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]   pcf_q, pcf_d, rsp_pc_q, rsp_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, discard_q, discard_d;
  logic [31:0]   instr_q, instr_d, pcd_q, pcd_d, pcp4_q, pcp4_d;
  logic          valid_q, valid_d;

  logic [31:0]   buf_instr_q [DEPTH];
  logic [31:0]   buf_pc_q    [DEPTH];

  logic [CW:0]   used;
  logic          req_fire, rsp_drop, push, pop;

  // Queued plus in-flight never exceeds DEPTH, so every response has a slot.
  assign used           = {1'b0, outst_q} + {1'b0, count_q};
  assign imem_req_valid = !rst && !PCSrcE && (used < DEPTH_C);
  assign imem_req_addr  = pcf_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_drop       = PCSrcE || (discard_q != '0);
  assign push           = imem_rsp_valid && !rsp_drop;
  assign pop            = !PCSrcE && !FlushD && !StallD && (count_q != '0);

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;

  always_comb begin
    pcf_d     = pcf_q;
    rsp_pc_d  = rsp_pc_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    discard_d = discard_q;
    outst_d   = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
    instr_d   = instr_q;
    pcd_d     = pcd_q;
    pcp4_d    = pcp4_q;
    valid_d   = valid_q;

    if (PCSrcE) begin
      // Everything still in flight after this cycle belongs to the old path.
      pcf_d     = PCTargetE;
      rsp_pc_d  = PCTargetE;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      discard_d = outst_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pcf_d = pcf_q + 32'd4;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      if (imem_rsp_valid && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
    end

    if (PCSrcE || FlushD) begin
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (StallD) begin
      instr_d = instr_q;
    end else if (count_q != '0) begin
      instr_d = buf_instr_q[rd_ptr_q];
      pcd_d   = buf_pc_q[rd_ptr_q];
      pcp4_d  = buf_pc_q[rd_ptr_q] + 32'd4;
      valid_d = 1'b1;
    end else begin
      instr_d = NOP;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcf_q     <= RESET_PC;
      rsp_pc_q  <= RESET_PC;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      outst_q   <= '0;
      discard_q <= '0;
      instr_q   <= NOP;
      pcd_q     <= 32'd0;
      pcp4_q    <= 32'd4;
      valid_q   <= 1'b0;
    end else begin
      pcf_q     <= pcf_d;
      rsp_pc_q  <= rsp_pc_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      instr_q   <= instr_d;
      pcd_q     <= pcd_d;
      pcp4_q    <= pcp4_d;
      valid_q   <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= imem_rsp_data;
      buf_pc_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_prefetch_stage
// Purpose  : Randomized bench for fetch_prefetch_stage with an imem model and
//            a queue-based reference of the fetch/decode stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_stage;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  fetch_prefetch_stage #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC),
    .NOP      (NOP)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .ValidD         (ValidD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } req_t;

  req_t        infl[$];
  logic [31:0] mq[$];
  logic [31:0] m_pcf;
  logic [31:0] e_instr, e_pc, e_pc4;
  logic        e_valid;
  int          cyc;
  int          n_checks;
  int          n_fail;
  int          lat_min, lat_max;
  bit          last_fire;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'd3 + 32'h1234_5670;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    infl.delete();
    mq.delete();
    m_pcf   = RESET_PC;
    e_instr = NOP;
    e_pc    = 32'd0;
    e_pc4   = 32'd4;
    e_valid = 1'b0;
  endtask

  task automatic check_ifid();
    chk("InstrD",   InstrD,   e_instr);
    chk("PCD",      PCD,      e_pc);
    chk("PCPlus4D", PCPlus4D, e_pc4);
    chk("ValidD",   {31'd0, ValidD}, {31'd0, e_valid});
  endtask

  // One cycle: drive at negedge, predict, clock, check IF/ID at next negedge.
  task automatic step(input bit stall, input bit flush, input bit redir,
                      input logic [31:0] tgt, input bit rdy);
    bit          exp_rv, rsp, do_pop, fire;
    req_t        r, e;
    logic [31:0] p;
    StallD         = stall;
    FlushD         = flush;
    PCSrcE         = redir;
    PCTargetE      = tgt;
    imem_req_ready = rdy;
    rsp            = (infl.size() > 0) && (infl[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(infl[0].addr) : $urandom;
    #1;
    exp_rv = !redir && ((infl.size() + mq.size()) < DEPTH);
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
    if (imem_req_valid) chk("req_addr", imem_req_addr, m_pcf);
    fire      = imem_req_valid && rdy;
    last_fire = fire;

    do_pop = !redir && !flush && !stall && (mq.size() > 0);
    if (redir || flush) begin
      e_instr = NOP;
      e_valid = 1'b0;
    end else if (stall) begin
      e_instr = e_instr;
    end else if (do_pop) begin
      p       = mq.pop_front();
      e_instr = mem_word(p);
      e_pc    = p;
      e_pc4   = p + 32'd4;
      e_valid = 1'b1;
    end else begin
      e_instr = NOP;
      e_valid = 1'b0;
    end

    if (rsp) begin
      r = infl.pop_front();
      if (!redir && !r.stale) mq.push_back(r.addr);
    end
    if (redir) begin
      mq.delete();
      foreach (infl[i]) infl[i].stale = 1'b1;
      m_pcf = tgt;
    end else if (fire) begin
      m_pcf = m_pcf + 32'd4;
    end
    if (fire) begin
      e.addr  = imem_req_addr;
      e.stale = 1'b0;
      e.due   = cyc + $urandom_range(lat_max, lat_min);
      if (infl.size() > 0 && infl[$].due > e.due) e.due = infl[$].due;
      infl.push_back(e);
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_ifid();
  endtask

  task automatic do_reset(input bit immediate);
    rst            = 1'b1;
    StallD         = 1'b0;
    FlushD         = 1'b0;
    PCSrcE         = 1'b0;
    PCTargetE      = 32'd0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    #1;
    model_reset();
    if (immediate) begin
      check_ifid();
      chk("req_valid_in_rst", {31'd0, imem_req_valid}, 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_ifid();
    chk("req_valid_held_rst", {31'd0, imem_req_valid}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_valid_pc(input string tag, input logic [31:0] exp_pc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      if (ValidD) begin
        found = 1'b1;
        chk(tag, PCD, exp_pc);
        chk({tag, "_plus4"}, PCPlus4D, exp_pc + 32'd4);
      end
    end
    chk({tag, "_seen"}, {31'd0, found}, 32'd1);
  endtask

  initial begin
    bit found, seen, stall_cur;
    int fires;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    lat_min  = 1;
    lat_max  = 1;
    do_reset(1'b0);

    // T1: straight streaming, latency 1, first valid on the third edge
    seen = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      if (!seen && ValidD) begin
        seen = 1'b1;
        chk("first_valid_edge", i, 3);
      end
    end
    chk("t1_valid_seen", {31'd0, seen}, 32'd1);

    // T2: stall from an empty pipe issues exactly DEPTH requests
    @(negedge clk);
    do_reset(1'b0);
    fires = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
      if (last_fire) fires++;
    end
    chk("stall_issue_count", fires, DEPTH);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // T3: redirect with three requests in flight
    lat_min = 3;
    lat_max = 3;
    found   = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (infl.size() == 3) found = 1'b1;
      else step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    end
    chk("t3_three_in_flight", {31'd0, found}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
    wait_valid_pc("t3_redir_pc", 32'h0000_0100);

    // T4: redirect coincident with a response and StallD
    lat_min = 2;
    lat_max = 2;
    found   = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (infl.size() >= 2 && infl[0].due <= cyc) found = 1'b1;
      else step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    end
    chk("t4_rsp_pending", {31'd0, found}, 32'd1);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
    wait_valid_pc("t4_redir_pc", 32'h0000_0200);

    // Single FlushD pulse in a steady stream
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // T5: random ready, latency 1..3, stalls, flushes and redirects
    lat_min   = 1;
    lat_max   = 3;
    stall_cur = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) < 20) stall_cur = !stall_cur;
      step(stall_cur,
           $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 5,
           {16'd0, 14'($urandom_range(0, 16383)), 2'b00},
           $urandom_range(0, 99) < 65);
    end

    // T6: reset mid-stream, then restart from RESET_PC
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    do_reset(1'b1);
    lat_min = 1;
    lat_max = 1;
    wait_valid_pc("t6_restart_pc", RESET_PC);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
